// File: rtl/fixed_input_replay_buffer_if.sv
// Valid/ready beat stream into and out of the input replay buffer.
// slave is the buffer side; master is the producer/consumer side.
interface fixed_input_replay_buffer_if #(
  parameter int IN_WIDTH = 32,
  parameter int IN_SIZE  = 4
);
  logic [IN_SIZE-1:0][IN_WIDTH-1:0] data_in;
  logic                             data_in_valid;
  logic                             data_in_ready;
  logic [IN_SIZE-1:0][IN_WIDTH-1:0] data_out;
  logic                             data_out_valid;
  logic                             data_out_ready;

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output data_in_ready, data_out, data_out_valid
  );

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  data_in_ready, data_out, data_out_valid
  );
endinterface

// File: rtl/fixed_input_replay_buffer.sv
// Forwards each input vector once while capturing it, then replays the stored
// beats REPEAT-1 more times on the same stream so fixed_linear sees it per tile.
module fixed_input_replay_buffer #(
  parameter int IN_WIDTH = 32,
  parameter int IN_SIZE  = 4,
  parameter int IN_DEPTH = 3,
  parameter int REPEAT   = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  fixed_input_replay_buffer_if.slave bus
);

  localparam int BEAT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int PASS_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  typedef enum logic {FILL, REPLAY} state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat_cnt;
  logic [PASS_W-1:0]   pass_cnt;
  logic [IN_SIZE-1:0][IN_WIDTH-1:0] mem [IN_DEPTH];

  logic beat_last;
  logic pass_last;
  logic fill_hs;

  assign beat_last = (beat_cnt == BEAT_W'(IN_DEPTH - 1));
  assign pass_last = (pass_cnt == PASS_W'(REPEAT - 1));
  assign fill_hs   = !rst && (state == FILL) && bus.data_in_valid && bus.data_out_ready;

  // Outputs are combinational from registered state so FILL is a true wire.
  always_comb begin
    bus.data_out       = bus.data_in;
    bus.data_out_valid = 1'b0;
    bus.data_in_ready  = 1'b0;
    if (!rst) begin
      if (state == FILL) begin
        bus.data_out_valid = bus.data_in_valid;
        bus.data_in_ready  = bus.data_out_ready;
      end else begin
        bus.data_out       = mem[beat_cnt];
        bus.data_out_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= FILL;
      beat_cnt <= '0;
      pass_cnt <= PASS_W'(1);
    end else begin
      case (state)
        FILL: begin
          if (fill_hs) begin
            if (beat_last) begin
              beat_cnt <= '0;
              if (REPEAT > 1) begin
                state    <= REPLAY;
                pass_cnt <= PASS_W'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        REPLAY: begin
          if (bus.data_out_ready) begin
            if (beat_last) begin
              beat_cnt <= '0;
              if (pass_last) begin
                state    <= FILL;
                pass_cnt <= PASS_W'(1);
              end else begin
                pass_cnt <= pass_cnt + PASS_W'(1);
              end
            end else begin
              beat_cnt <= beat_cnt + BEAT_W'(1);
            end
          end
        end
        default: begin
          state    <= FILL;
          beat_cnt <= '0;
          pass_cnt <= PASS_W'(1);
        end
      endcase
    end
  end

  // Storage only written on FILL handshakes, so replayed beats hold under stall.
  always_ff @(posedge clk) begin
    if (fill_hs) begin
      mem[beat_cnt] <= bus.data_in;
    end
  end

endmodule

// File: tb/tb_fixed_input_replay_buffer.sv
// Drives four buffer configurations from one shared stream and checks each
// against a queue-based model of forward-once-then-replay behaviour.
module tb_fixed_input_replay_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] din;
  logic         din_valid;
  logic         dout_ready;
  int           rdy_mode = 0;
  int           rdy_k = 0;
  int           n_cmp = 0;
  int           n_bad = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : inst
    localparam int D = (g == 3) ? 1 : 3;
    localparam int R = (g == 0) ? 2 : (g == 1) ? 3 : (g == 2) ? 1 : 4;

    fixed_input_replay_buffer_if #(.IN_WIDTH(32), .IN_SIZE(4)) u_if ();

    assign u_if.data_in        = din;
    assign u_if.data_in_valid  = din_valid;
    assign u_if.data_out_ready = dout_ready;

    fixed_input_replay_buffer #(
      .IN_WIDTH(32), .IN_SIZE(4), .IN_DEPTH(D), .REPEAT(R)
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if.slave)
    );

    logic [127:0] replay_q[$];
    logic [127:0] cur_vec[$];

    always @(negedge clk) begin
      if (rst) begin
        check($sformatf("g%0d rst in_ready", g), 128'(u_if.data_in_ready), 128'(0));
        check($sformatf("g%0d rst out_valid", g), 128'(u_if.data_out_valid), 128'(0));
        replay_q.delete();
        cur_vec.delete();
      end else if (replay_q.size() > 0) begin
        check($sformatf("g%0d replay in_ready", g), 128'(u_if.data_in_ready), 128'(0));
        check($sformatf("g%0d replay out_valid", g), 128'(u_if.data_out_valid), 128'(1));
        check($sformatf("g%0d replay data", g), u_if.data_out, replay_q[0]);
        if (dout_ready) void'(replay_q.pop_front());
      end else begin
        check($sformatf("g%0d fill out_valid", g), 128'(u_if.data_out_valid), 128'(din_valid));
        check($sformatf("g%0d fill in_ready", g), 128'(u_if.data_in_ready), 128'(dout_ready));
        check($sformatf("g%0d fill data", g), u_if.data_out, din);
        if (din_valid && dout_ready) begin
          cur_vec.push_back(din);
          if (cur_vec.size() == D) begin
            for (int r = 1; r < R; r++)
              for (int b = 0; b < D; b++) replay_q.push_back(cur_vec[b]);
            cur_vec.delete();
          end
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) begin
      dout_ready = ((rdy_k % 3) == 0);
      rdy_k++;
    end
  end

  function automatic logic [127:0] mk(input int a, input int b, input int c, input int d);
    return {d[31:0], c[31:0], b[31:0], a[31:0]};
  endfunction

  // Offer one beat until configuration 0 accepts it (bounded).
  task automatic send(input logic [127:0] b);
    int n = 0;
    din = b;
    din_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!(inst[0].u_if.data_in_ready && dout_ready) && n < 60);
    if (n >= 60) check("send timeout", 128'(0), 128'(1));
    @(posedge clk);
    #1;
    din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
  endtask

  logic [127:0] a_b, b_b, c_b, d_b, e_b, f_b, g_b, h_b, i_b, x_b;

  initial begin
    a_b = mk(1, 2, 3, 4);    b_b = mk(5, 6, 7, 8);    c_b = mk(9, 10, 11, 12);
    d_b = mk(13, 14, 15, 16); e_b = mk(17, 18, 19, 20); f_b = mk(21, 22, 23, 24);
    g_b = mk(31, 32, 33, 34); h_b = mk(35, 36, 37, 38); i_b = mk(39, 40, 41, 42);
    x_b = mk(-1, 0, 7, -8);
    rst = 1'b1; din = '0; din_valid = 1'b0; dout_ready = 1'b1;
    idle(3);
    rst = 1'b0;

    send(a_b); send(b_b); send(c_b);
    send(d_b); send(e_b); send(f_b);
    idle(12);

    pulse_rst();
    rdy_mode = 1;
    send(a_b); send(b_b); send(c_b);
    idle(20);
    rdy_mode = 0;
    dout_ready = 1'b1;
    idle(10);

    pulse_rst();
    send(a_b); send(b_b); send(c_b);
    idle(2);
    pulse_rst();
    send(g_b); send(h_b); send(i_b);
    idle(12);

    pulse_rst();
    din = x_b;
    din_valid = 1'b1;
    idle(1);
    din_valid = 1'b0;
    idle(8);

    pulse_rst();
    for (int k = 0; k < 500; k++) begin
      rst        = ($urandom_range(0, 59) == 0);
      din        = {$urandom(), $urandom(), $urandom(), $urandom()};
      din_valid  = $urandom_range(0, 1) == 1;
      dout_ready = $urandom_range(0, 3) != 0;
      idle(1);
    end
    rst = 1'b0;
    din_valid = 1'b0;
    dout_ready = 1'b1;
    idle(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
